// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared types for the memory port master.
// Holds the FSM state and status encodings and the latched request record.
// The request fields are sized from the default memory geometry. A wider
// WIDTH or deeper LENGTH on the master needs these localparams raised to match.
package mem_if_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} mem_state_t;
    typedef enum logic [1:0] {ST_OK = 2'd0, ST_FAULT = 2'd1, ST_TIMEOUT = 2'd2} mem_status_t;
    localparam int MEM_WIDTH  = 32;
    localparam int MEM_LENGTH = 1024;
    localparam int MEM_ADDR_W = $clog2(MEM_LENGTH);
    typedef struct packed {
        logic                  write;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_WIDTH-1:0]  wdata;
    } mem_req_t;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts cycles spent waiting for a memory reply.
// Ports: clk, rst (sync, active-high), clear (zero the count), enable (count this
// cycle), expired (high on the TIMEOUT-th enabled cycle since the last clear).
module mem_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q;
    // Count reaches TIMEOUT-1 on the TIMEOUT-th enabled cycle, so expiry is
    // reported combinationally in that same cycle.
    assign expired = enable && (cnt_q == CNT_W'(TIMEOUT - 1));
    always_ff @(posedge clk) begin
        if (rst || clear) cnt_q <= '0;
        else if (enable) cnt_q <= cnt_q + 1'b1;
    end
endmodule

// File: rtl/mem_port_master.sv
// mem_port_master: single-outstanding load/store requester for a memory read/write port pair.
// Ports: clk, rst (sync, active-high); request channel req_valid/req_ready/req_write/
// req_addr/req_wdata; response channel rsp_valid/rsp_ready/rsp_rdata/rsp_status;
// memory read port mem_read_addr/enable/data/valid/done; memory write port
// mem_write_addr/enable/data/valid/done. All outputs are registered.
module mem_port_master
    import mem_if_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int LENGTH  = 1024,
    parameter int TIMEOUT = 16,
    localparam int ADDR_W = $clog2(LENGTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WIDTH-1:0]  req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_rdata,
    output logic [1:0]        rsp_status,
    output logic [ADDR_W-1:0] mem_read_addr,
    output logic              mem_read_enable,
    input  logic [WIDTH-1:0]  mem_read_data,
    input  logic              mem_read_valid,
    input  logic              mem_read_done,
    output logic [ADDR_W-1:0] mem_write_addr,
    output logic              mem_write_enable,
    output logic [WIDTH-1:0]  mem_write_data,
    input  logic              mem_write_valid,
    input  logic              mem_write_done
);
    mem_state_t state_q, state_d;
    mem_req_t req_q, req_d;
    mem_status_t rsp_status_q, rsp_status_d;
    logic [WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic req_ready_q, rsp_valid_q, rd_en_q, wr_en_q, issue_rd, issue_wr;
    logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;
    logic [WIDTH-1:0] wr_data_q;
    logic done, hit, expired;
    // Only the port matching the latched op can complete it.
    assign done = req_q.write ? mem_write_done : mem_read_done;
    assign hit = req_q.write ? mem_write_valid : mem_read_valid;
    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q != WAIT),
        .enable (state_q == WAIT),
        .expired(expired)
    );
    always_comb begin
        state_d = state_q;
        req_d = req_q;
        rsp_status_d = rsp_status_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            IDLE: if (req_valid && req_ready_q) begin
                req_d.write = req_write;
                req_d.addr = MEM_ADDR_W'(req_addr);
                req_d.wdata = MEM_WIDTH'(req_wdata);
                // Out-of-range addresses never reach memory.
                state_d = (32'(req_addr) < 32'(LENGTH)) ? ISSUE : RESP;
                rsp_status_d = (32'(req_addr) < 32'(LENGTH)) ? ST_OK : ST_FAULT;
                rsp_rdata_d = '0;
            end
            ISSUE: state_d = WAIT;
            WAIT: if (done || expired) begin
                // A done in the expiry cycle still counts as a reply.
                state_d = RESP;
                rsp_status_d = !done ? ST_TIMEOUT : hit ? ST_OK : ST_FAULT;
                rsp_rdata_d = (done && hit && !req_q.write) ? mem_read_data : '0;
            end
            RESP: if (rsp_ready) begin
                state_d = IDLE;
                rsp_status_d = ST_OK;
                rsp_rdata_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end
    assign issue_rd = (state_d == ISSUE) && !req_d.write;
    assign issue_wr = (state_d == ISSUE) && req_d.write;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q <= '0;
            rsp_status_q <= ST_OK;
            rsp_rdata_q <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q <= state_d;
            req_q <= req_d;
            rsp_status_q <= rsp_status_d;
            rsp_rdata_q <= rsp_rdata_d;
            req_ready_q <= state_d == IDLE;
            rsp_valid_q <= state_d == RESP;
            rd_en_q <= issue_rd;
            wr_en_q <= issue_wr;
            rd_addr_q <= issue_rd ? ADDR_W'(req_d.addr) : '0;
            wr_addr_q <= issue_wr ? ADDR_W'(req_d.addr) : '0;
            wr_data_q <= issue_wr ? WIDTH'(req_d.wdata) : '0;
        end
    end
    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_status = rsp_status_q;
    assign mem_read_enable = rd_en_q;
    assign mem_read_addr = rd_addr_q;
    assign mem_write_enable = wr_en_q;
    assign mem_write_addr = wr_addr_q;
    assign mem_write_data = wr_data_q;
endmodule
